sram_arbiter: RTL and testbench

Shares the single external-SRAM controller between three requesters: the video read port (highest priority), the pen-pixel write port, and a background framebuffer clear engine (lowest priority).
- Issues one command at a time to the controller using its ready/read/write handshake.
- Returns read data to the video port.
- Walks the whole address space for a clear.
- Sits between the tracking/video logic and the SRAM controller in the top level.

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_clear_walker.sv | 39 +++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and width defaults for the SRAM arbiter.
package sram_arbiter_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_RD  = 2'd0,
        GNT_WR  = 2'd1,
        GNT_CLR = 2'd2
    } gnt_t;

endpackage

// File: rtl/sram_clear_walker.sv
// Framebuffer clear sequencer: busy/done flags plus the address walk 0..CLR_LAST.
module sram_clear_walker
    import sram_arbiter_pkg::*;
#(
    parameter int                ADDR_W   = SRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] CLR_LAST = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_done,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            addr <= '0;
        end else begin
            done <= 1'b0;
            if (busy && wr_done) begin
                if (addr == CLR_LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    addr <= '0;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end else if (start && !busy) begin
                busy <= 1'b1;
                addr <= '0;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter (video read > pen write > clear) in front of the SRAM controller.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int                ADDR_W     = SRAM_ADDR_W,
    parameter int                DATA_W     = SRAM_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VALUE  = '0,
    parameter logic [ADDR_W-1:0] CLR_LAST   = 18'h3FFFF,
    parameter int                RD_MAX_RUN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_write,
    input  logic [DATA_W-1:0] sram_data_read,
    input  logic              sram_ready
);

    localparam int RUN_W = $clog2(RD_MAX_RUN + 1);

    state_t             state;
    gnt_t               gnt;
    logic               seen_busy;
    logic [RUN_W-1:0]   rd_run;
    logic [ADDR_W-1:0]  clr_addr;
    logic               lower_pend;
    logic               guard;
    logic               cmd_done;
    logic               clr_wr_done;

    assign lower_pend  = wr_req | clr_busy;
    assign guard       = (rd_run == RUN_W'(RD_MAX_RUN)) && lower_pend;
    assign cmd_done    = (state == WAIT) && seen_busy && sram_ready;
    assign clr_wr_done = cmd_done && (gnt == GNT_CLR);

    sram_clear_walker #(
        .ADDR_W   (ADDR_W),
        .CLR_LAST (CLR_LAST)
    ) u_walker (
        .clk     (clk),
        .reset   (reset),
        .start   (clr_start),
        .wr_done (clr_wr_done),
        .busy    (clr_busy),
        .done    (clr_done),
        .addr    (clr_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gnt             <= GNT_RD;
            seen_busy       <= 1'b0;
            rd_run          <= '0;
            rd_ack          <= 1'b0;
            wr_ack          <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            sram_read       <= 1'b0;
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_data_write <= '0;
        end else begin
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // The guard only diverts a read once the run limit is hit with someone waiting.
                    if (sram_ready && rd_req && !guard) begin
                        gnt          <= GNT_RD;
                        sram_address <= rd_addr;
                        sram_read    <= 1'b1;
                        rd_ack       <= 1'b1;
                        rd_run       <= lower_pend ? rd_run + RUN_W'(1) : '0;
                        seen_busy    <= 1'b0;
                        state        <= CMD;
                    end else if (sram_ready && wr_req) begin
                        gnt             <= GNT_WR;
                        sram_address    <= wr_addr;
                        sram_data_write <= wr_data;
                        sram_write      <= 1'b1;
                        wr_ack          <= 1'b1;
                        rd_run          <= '0;
                        seen_busy       <= 1'b0;
                        state           <= CMD;
                    end else if (sram_ready && clr_busy) begin
                        gnt             <= GNT_CLR;
                        sram_address    <= clr_addr;
                        sram_data_write <= CLR_VALUE;
                        sram_write      <= 1'b1;
                        rd_run          <= '0;
                        seen_busy       <= 1'b0;
                        state           <= CMD;
                    end else if (!lower_pend) begin
                        rd_run <= '0;
                    end
                end
                CMD: begin
                    sram_read  <= 1'b0;
                    sram_write <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // Ready may still be high right after the strobe; wait for the busy phase first.
                    if (!sram_ready) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state <= IDLE;
                        if (gnt == GNT_RD) begin
                            rd_data  <= sram_data_read;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM controller model.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int             AW    = 18;
    localparam int             DW    = 16;
    localparam logic [AW-1:0]  CLAST = 18'h0000F;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk, reset;
    logic          rd_req, rd_ack, rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_req, wr_ack;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_start, clr_busy, clr_done;
    logic          sram_read, sram_write, sram_ready;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data_write, sram_data_read;

    cmd_t          exp_cmd[$];
    logic [DW-1:0] exp_rd[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_wr_cyc = 0;
    logic [2:0]    bcnt;

    sram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .CLR_VALUE  (16'h0000),
        .CLR_LAST   (CLAST),
        .RD_MAX_RUN (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ack          (rd_ack),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .clr_start       (clr_start),
        .clr_busy        (clr_busy),
        .clr_done        (clr_done),
        .sram_read       (sram_read),
        .sram_write      (sram_write),
        .sram_address    (sram_address),
        .sram_data_write (sram_data_write),
        .sram_data_read  (sram_data_read),
        .sram_ready      (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 18'h00123) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Controller: busy for four cycles after the strobe, ready again five cycles after it.
    always @(posedge clk) begin
        if (reset) begin
            sram_ready     <= 1'b1;
            bcnt           <= 3'd0;
            sram_data_read <= '0;
        end else if (sram_read || sram_write) begin
            sram_ready <= 1'b0;
            bcnt       <= 3'd3;
            if (sram_read) sram_data_read <= mem_val(sram_address);
        end else if (!sram_ready) begin
            if (bcnt == 3'd0) sram_ready <= 1'b1;
            else              bcnt <= bcnt - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cmd_t          e;
        logic [DW-1:0] d;
        if (!reset) begin
            if (sram_read || sram_write) begin
                chk("one_strobe", 64'(sram_read & sram_write), 64'd0);
                if (exp_cmd.size() == 0) begin
                    chk("unexp_cmd", 64'(sram_address), 64'h1_0000_0000);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_wr", 64'(sram_write), 64'(e.wr));
                    chk("cmd_addr", 64'(sram_address), 64'(e.addr));
                    if (e.wr) chk("cmd_data", 64'(sram_data_write), 64'(e.data));
                end
                if (sram_write) last_wr_cyc <= cyc;
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    chk("unexp_rd_valid", 64'(rd_data), 64'h1_0000_0000);
                end else begin
                    d = exp_rd.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(d));
                end
            end
        end
    end

    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        push_cmd(1'b0, a, '0);
        exp_rd.push_back(mem_val(a));
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                rd_req = 1'b0;
                return;
            end
        end
        chk("rd_ack_timeout", 64'd0, 64'd1);
        rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                wr_req = 1'b0;
                return;
            end
        end
        chk("wr_ack_timeout", 64'd0, 64'd1);
        wr_req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
    endtask

    task automatic wait_clr_done(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (clr_done) begin
                at = cyc;
                return;
            end
        end
        chk(tag, 64'd0, 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (exp_cmd.size() == 0 && exp_rd.size() == 0) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk(tag, 64'(exp_cmd.size() + exp_rd.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat, done_at;
        logic saw;
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; clr_start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_flags", 64'({rd_ack, rd_valid, wr_ack, clr_busy, clr_done, sram_read, sram_write}), 64'd0);
        chk("rst_addr", 64'(sram_address), 64'd0);
        chk("rst_wdata", 64'(sram_data_write), 64'd0);
        chk("rst_rdata", 64'(rd_data), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single read: ack in cycle 1, rd_valid in cycle 7
        push_rd(18'h00123);
        rd_req = 1'b1; rd_addr = 18'h00123;
        @(negedge clk);
        chk("single_ack", 64'(rd_ack), 64'd1);
        chk("single_strobe", 64'(sram_read), 64'd1);
        rd_req = 1'b0;
        @(negedge clk);
        chk("single_strobe_drop", 64'(sram_read), 64'd0);
        lat = 2;
        while (!rd_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_valid_cycle", 64'(lat), 64'd7);
        drain("single_drain");

        // Priority: read then write
        push_rd(18'h00200);
        push_cmd(1'b1, 18'h00201, 16'hA5C3);
        fork
            do_read(18'h00200);
            do_write(18'h00201, 16'hA5C3);
        join
        drain("prio_drain");

        // Starvation guard: 8 reads, the write, then reads resume
        for (int i = 0; i < 8; i++) push_rd(AW'(32'h300 + i));
        push_cmd(1'b1, 18'h00777, 16'h1357);
        for (int i = 8; i < 10; i++) push_rd(AW'(32'h300 + i));
        fork
            begin
                for (int i = 0; i < 10; i++) do_read(AW'(32'h300 + i));
            end
            do_write(18'h00777, 16'h1357);
        join
        drain("starve_drain");

        // Clear 0..15, with a second start mid-clear that must be ignored
        for (int i = 0; i <= 15; i++) push_cmd(1'b1, AW'(i), 16'h0000);
        pulse_clr();
        chk("clr_busy_on", 64'(clr_busy), 64'd1);
        repeat (40) @(negedge clk);
        pulse_clr();
        chk("clr_busy_mid", 64'(clr_busy), 64'd1);
        wait_clr_done("clr_done_timeout", done_at);
        chk("clr_done_lat", 64'(done_at - last_wr_cyc), 64'd6);
        chk("clr_busy_off", 64'(clr_busy), 64'd0);
        @(negedge clk);
        chk("clr_done_pulse", 64'(clr_done), 64'd0);
        drain("clr_drain");

        // Pen write interleaved into a clear
        for (int i = 0; i <= 2; i++) push_cmd(1'b1, AW'(i), 16'h0000);
        push_cmd(1'b1, 18'h2ABCD, 16'h1234);
        for (int i = 3; i <= 15; i++) push_cmd(1'b1, AW'(i), 16'h0000);
        pulse_clr();
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sram_write && sram_address == 18'h00002) begin
                saw = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ilv_third_clear_seen", 64'(saw), 64'd1);
        do_write(18'h2ABCD, 16'h1234);
        wait_clr_done("ilv_done_timeout", done_at);
        drain("ilv_drain");

        // Reset while a read is in WAIT: no rd_valid, then a fresh read works
        push_cmd(1'b0, 18'h00400, '0);
        do_read(18'h00400);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", 64'({rd_ack, rd_valid, wr_ack, clr_busy, clr_done, sram_read, sram_write}), 64'd0);
        chk("mid_rst_addr", 64'(sram_address), 64'd0);
        chk("mid_rst_rdata", 64'(rd_data), 64'd0);
        reset = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw = saw | rd_valid;
        end
        chk("mid_rst_no_valid", 64'(saw), 64'd0);
        push_rd(18'h00401);
        do_read(18'h00401);
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
